// File: rtl/mio_bus_dma.sv
// MIO bus DMA initiator: copies a block of 32-bit words from a source to a destination
// address with mem_rd/mem_w transactions, sharing the bus through a req/gnt arbiter.
module mio_bus_dma #(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [CNT_W-1:0] word_cnt_i,
    input  logic             src_inc_i,
    input  logic             dst_inc_i,
    input  logic             abort_i,
    input  logic             bus_gnt_i,
    input  logic [31:0]      bus_data_in_i,
    output logic             bus_req_o,
    output logic             mem_rd_o,
    output logic             mem_w_o,
    output logic [31:0]      addr_bus_o,
    output logic [31:0]      bus_data_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] words_left_o
);

    localparam int RDC_W = $clog2(RD_LAT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_ptr_q, src_ptr_d;
    logic [31:0]      dst_ptr_q, dst_ptr_d;
    logic [31:0]      data_q, data_d;
    logic             src_inc_q, src_inc_d;
    logic             dst_inc_q, dst_inc_d;
    logic             abort_q, abort_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] words_left_q, words_left_d;
    logic [RDC_W-1:0] rd_cnt_q, rd_cnt_d;

    logic misaligned;
    logic abort_seen;
    logic rd_last;
    logic last_word;

    assign misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);
    assign abort_seen = abort_q || abort_i;
    assign rd_last    = (rd_cnt_q == RDC_W'(RD_LAT));
    assign last_word  = (words_left_q == CNT_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant is only consulted at word boundaries (REQ, or leaving WR).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (misaligned || (word_cnt_i == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (abort_seen) begin
                    state_d = S_DONE;
                end else if (bus_gnt_i) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (rd_last) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (last_word || abort_seen) begin
                    state_d = S_DONE;
                end else if (bus_gnt_i) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        data_d       = data_q;
        src_inc_d    = src_inc_q;
        dst_inc_d    = dst_inc_q;
        abort_d      = abort_q;
        err_d        = err_q;
        words_left_d = words_left_q;
        rd_cnt_d     = rd_cnt_q;

        if (((state_q == S_REQ) || (state_q == S_RD) || (state_q == S_WR)) && abort_i) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    abort_d      = 1'b0;
                    rd_cnt_d     = '0;
                    words_left_d = '0;
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        if (word_cnt_i != '0) begin
                            src_ptr_d    = src_addr_i;
                            dst_ptr_d    = dst_addr_i;
                            src_inc_d    = src_inc_i;
                            dst_inc_d    = dst_inc_i;
                            words_left_d = word_cnt_i;
                        end
                    end
                end
            end
            S_RD: begin
                if (rd_last) begin
                    data_d   = bus_data_in_i;
                    rd_cnt_d = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + RDC_W'(1);
                end
            end
            S_WR: begin
                words_left_d = words_left_q - CNT_W'(1);
                if (src_inc_q) begin
                    src_ptr_d = src_ptr_q + 32'd4;
                end
                if (dst_inc_q) begin
                    dst_ptr_d = dst_ptr_q + 32'd4;
                end
            end
            S_DONE: begin
                abort_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            data_q       <= '0;
            src_inc_q    <= 1'b0;
            dst_inc_q    <= 1'b0;
            abort_q      <= 1'b0;
            err_q        <= 1'b0;
            words_left_q <= '0;
            rd_cnt_q     <= '0;
        end else begin
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            data_q       <= data_d;
            src_inc_q    <= src_inc_d;
            dst_inc_q    <= dst_inc_d;
            abort_q      <= abort_d;
            err_q        <= err_d;
            words_left_q <= words_left_d;
            rd_cnt_q     <= rd_cnt_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        bus_req_o      = 1'b0;
        mem_rd_o       = 1'b0;
        mem_w_o        = 1'b0;
        addr_bus_o     = '0;
        bus_data_out_o = '0;
        done_o         = 1'b0;
        busy_o         = (state_q != S_IDLE);
        case (state_q)
            S_REQ: begin
                bus_req_o = 1'b1;
            end
            S_RD: begin
                bus_req_o  = 1'b1;
                mem_rd_o   = 1'b1;
                addr_bus_o = src_ptr_q;
            end
            S_WR: begin
                bus_req_o      = 1'b1;
                mem_w_o        = 1'b1;
                addr_bus_o     = dst_ptr_q;
                bus_data_out_o = data_q;
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign err_o        = err_q;
    assign words_left_o = words_left_q;

endmodule

// File: tb/tb_mio_bus_dma.sv
// Self-checking bench for mio_bus_dma: a RAM model answers reads after RD_LAT cycles and
// a scoreboard of expected writes is compared against every mem_w cycle.
module tb_mio_bus_dma;

    localparam int RD_LAT = 1;
    localparam int CNT_W  = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      srcAddr;
    logic [31:0]      dstAddr;
    logic [CNT_W-1:0] wordCnt;
    logic             srcInc;
    logic             dstInc;
    logic             abortIn;
    logic             busGnt;
    logic [31:0]      busDataIn;
    logic             busReq;
    logic             memRd;
    logic             memW;
    logic [31:0]      addrBus;
    logic [31:0]      busDataOut;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] wordsLeft;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    int  cycle = 0;
    int  rdRun = 0;
    int  wrCount = 0;
    int  rdCount = 0;
    int  reqCount = 0;
    int  doneCount = 0;
    wr_t sbQ[$];
    wr_t expWr;
    int  wrCycles[$];
    logic [31:0] ram [logic [31:0]];

    mio_bus_dma #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .src_addr_i    (srcAddr),
        .dst_addr_i    (dstAddr),
        .word_cnt_i    (wordCnt),
        .src_inc_i     (srcInc),
        .dst_inc_i     (dstInc),
        .abort_i       (abortIn),
        .bus_gnt_i     (busGnt),
        .bus_data_in_i (busDataIn),
        .bus_req_o     (busReq),
        .mem_rd_o      (memRd),
        .mem_w_o       (memW),
        .addr_bus_o    (addrBus),
        .bus_data_out_o(busDataOut),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .words_left_o  (wordsLeft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rdata(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    // Read data is only valid once the strobe has been up for RD_LAT cycles.
    always @* begin
        busDataIn = (memRd && (rdRun >= RD_LAT)) ? rdata(addrBus) : 32'hDEAD_BEEF;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) rdRun <= 0;
        else rdRun <= memRd ? rdRun + 1 : 0;
    end

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (memRd && memW) begin
                errors++;
                $display("[TB] FAIL strobe_overlap: mem_rd=%b mem_w=%b, required not both", memRd, memW);
            end
            if (!memRd && !memW) begin
                checks++;
                if (addrBus !== 32'h0 || busDataOut !== 32'h0) begin
                    errors++;
                    $display("[TB] FAIL idle_bus: addr=%h data=%h, required 0/0", addrBus, busDataOut);
                end
            end
            if (busReq) reqCount++;
            if (memRd) rdCount++;
            if (done) doneCount++;
            if (memW) begin
                wrCount++;
                wrCycles.push_back(cycle);
                checks++;
                if (sbQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: addr=%h data=%h, none expected", addrBus, busDataOut);
                end else begin
                    expWr = sbQ.pop_front();
                    if (addrBus !== expWr.addr || busDataOut !== expWr.data) begin
                        errors++;
                        $display("[TB] FAIL write: addr=%h data=%h, required addr=%h data=%h",
                                 addrBus, busDataOut, expWr.addr, expWr.data);
                    end
                end
            end
        end
    end

    task automatic clearCounters();
        wrCount = 0;
        rdCount = 0;
        reqCount = 0;
        doneCount = 0;
        wrCycles.delete();
    endtask

    task automatic pushExpected(input logic [31:0] src, input logic [31:0] dst, input int n,
                                input logic sinc, input logic dinc);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = dst + (dinc ? 32'(4 * i) : 32'h0);
            w.data = rdata(src + (sinc ? 32'(4 * i) : 32'h0));
            sbQ.push_back(w);
        end
    endtask

    // Pulses start for one cycle; returns on the negedge after the accepting edge.
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int n,
                                 input logic sinc, input logic dinc);
        @(negedge clk);
        srcAddr = src;
        dstAddr = dst;
        wordCnt = CNT_W'(n);
        srcInc  = sinc;
        dstInc  = dinc;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s_timeout: done not seen within %0d cycles, required done=1", name, budget);
        end
    endtask

    task automatic waitWrite(input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (memW === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s_wr_timeout: mem_w not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busReq, memRd, memW, busy, done, err} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: req/rd/w/busy/done/err=%b, required 000000",
                     {busReq, memRd, memW, busy, done, err});
        end
        checks++;
        if (addrBus !== 32'h0 || busDataOut !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus: addr=%h data=%h, required 0", addrBus, busDataOut);
        end
        checks++;
        if (wordsLeft !== '0) begin
            errors++;
            $display("[TB] FAIL reset_words_left: got %0d, required 0", wordsLeft);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        clearCounters();
        applyStimulus(32'h102, 32'h1000, 2, 1'b1, 1'b1);
        checks++;
        if (done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misaligned_done_err: done=%b err=%b, required 1/1", done, err);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rdCount != 0 || wrCount != 0 || reqCount != 0) begin
            errors++;
            $display("[TB] FAIL misaligned_bus: rd=%0d wr=%0d req=%0d, required 0/0/0", rdCount, wrCount, reqCount);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky: err=%b, required 1", err);
        end
    endtask

    task automatic test_copy3();
        clearCounters();
        ram[32'h100] = 32'd11;
        ram[32'h104] = 32'd22;
        ram[32'h108] = 32'd33;
        pushExpected(32'h100, 32'hB800_0000, 3, 1'b1, 1'b1);
        applyStimulus(32'h100, 32'hB800_0000, 3, 1'b1, 1'b1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_clear: err=%b, required 0", err);
        end
        waitDone(40, "copy3");
        checks++;
        if (busy !== 1'b1 || wordsLeft !== 16'd0) begin
            errors++;
            $display("[TB] FAIL copy3_done_cycle: busy=%b words_left=%0d, required 1/0", busy, wordsLeft);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wrCount != 3 || doneCount != 1 || sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL copy3_counts: wr=%0d done=%0d pending=%0d, required 3/1/0",
                     wrCount, doneCount, sbQ.size());
        end
        checks++;
        if (wrCycles.size() != 3 || wrCycles[1] - wrCycles[0] != 3 || wrCycles[2] - wrCycles[1] != 3) begin
            errors++;
            $display("[TB] FAIL copy3_spacing: %0d writes, gaps not all 3 cycles", wrCycles.size());
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL copy3_idle: busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_zero_count();
        clearCounters();
        applyStimulus(32'h100, 32'h200, 0, 1'b1, 1'b1);
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_done: done=%b err=%b, required 1/0", done, err);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rdCount != 0 || wrCount != 0 || doneCount != 1) begin
            errors++;
            $display("[TB] FAIL zero_bus: rd=%0d wr=%0d done=%0d, required 0/0/1", rdCount, wrCount, doneCount);
        end
    endtask

    task automatic test_grant_stall();
        clearCounters();
        pushExpected(32'h200, 32'h300, 3, 1'b1, 1'b1);
        applyStimulus(32'h200, 32'h300, 3, 1'b1, 1'b1);
        waitWrite(20, "stall");
        busGnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busReq !== 1'b1 || memRd !== 1'b0 || memW !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_req: req=%b rd=%b w=%b, required 1/0/0", busReq, memRd, memW);
            end
        end
        busGnt = 1'b1;
        waitDone(40, "stall");
        repeat (2) @(negedge clk);
        checks++;
        if (wrCount != 3 || sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL stall_counts: wr=%0d pending=%0d, required 3/0", wrCount, sbQ.size());
        end
    endtask

    task automatic test_fixed_dst();
        clearCounters();
        pushExpected(32'h400, 32'hE000_0000, 4, 1'b1, 1'b0);
        applyStimulus(32'h400, 32'hE000_0000, 4, 1'b1, 1'b0);
        waitDone(50, "fixed_dst");
        repeat (2) @(negedge clk);
        checks++;
        if (wrCount != 4 || sbQ.size() != 0 || doneCount != 1) begin
            errors++;
            $display("[TB] FAIL fixed_dst_counts: wr=%0d pending=%0d done=%0d, required 4/0/1",
                     wrCount, sbQ.size(), doneCount);
        end
    endtask

    task automatic test_abort_rd();
        bit sawRd = 0;
        clearCounters();
        pushExpected(32'h500, 32'h600, 2, 1'b1, 1'b1);
        applyStimulus(32'h500, 32'h600, 5, 1'b1, 1'b1);
        waitWrite(20, "abort_rd");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (memRd === 1'b1) begin
                sawRd = 1;
                break;
            end
        end
        checks++;
        if (!sawRd) begin
            errors++;
            $display("[TB] FAIL abort_rd_word2: second read not seen, required mem_rd=1");
        end
        abortIn = 1'b1;
        @(negedge clk);
        abortIn = 1'b0;
        waitDone(20, "abort_rd");
        checks++;
        if (wordsLeft !== 16'd3) begin
            errors++;
            $display("[TB] FAIL abort_rd_words_left: got %0d, required 3", wordsLeft);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wrCount != 2 || sbQ.size() != 0 || doneCount != 1) begin
            errors++;
            $display("[TB] FAIL abort_rd_counts: wr=%0d pending=%0d done=%0d, required 2/0/1",
                     wrCount, sbQ.size(), doneCount);
        end
    endtask

    task automatic test_abort_req();
        clearCounters();
        busGnt = 1'b0;
        applyStimulus(32'h700, 32'h800, 2, 1'b1, 1'b1);
        abortIn = 1'b1;
        @(negedge clk);
        abortIn = 1'b0;
        checks++;
        if (done !== 1'b1 || wordsLeft !== 16'd2) begin
            errors++;
            $display("[TB] FAIL abort_req_done: done=%b words_left=%0d, required 1/2", done, wordsLeft);
        end
        busGnt = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rdCount != 0 || wrCount != 0) begin
            errors++;
            $display("[TB] FAIL abort_req_bus: rd=%0d wr=%0d, required 0/0", rdCount, wrCount);
        end
    endtask

    task automatic test_reset_mid_write();
        int doneBefore;
        clearCounters();
        pushExpected(32'h900, 32'hA00, 3, 1'b1, 1'b1);
        applyStimulus(32'h900, 32'hA00, 3, 1'b1, 1'b1);
        waitWrite(20, "reset_mid");
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (memW !== 1'b0 || busReq !== 1'b0 || busy !== 1'b0 || addrBus !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_wr: w=%b req=%b busy=%b addr=%h, required 0/0/0/0",
                     memW, busReq, busy, addrBus);
        end
        @(negedge clk);
        rst = 1'b0;
        sbQ.delete();
        doneBefore = doneCount;
        repeat (4) @(negedge clk);
        checks++;
        if (doneCount != doneBefore || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_no_done: done pulses=%0d busy=%b, required 0/0",
                     doneCount - doneBefore, busy);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        srcAddr = '0;
        dstAddr = '0;
        wordCnt = '0;
        srcInc  = 1'b0;
        dstInc  = 1'b0;
        abortIn = 1'b0;
        busGnt  = 1'b1;
        test_reset();
        test_misaligned();
        test_copy3();
        test_zero_count();
        test_grant_stall();
        test_fixed_dst();
        test_abort_rd();
        test_abort_req();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
